// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    // Sequencer state: normal flow or EX occupied by a multi-cycle mul/div.
    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } ctrl_state_e;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default timing constants.
    localparam int DEF_MULDIV_CYCLES = 4;
    localparam int DEF_MEM_TIMEOUT   = 15;
    localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       luh
);

    // rs is always treated as a source; rt only when the ID instruction reads it.
    always_comb begin
        luh = ex_mem_read && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze with watchdog,
// taken-branch flush, mul/div EX occupancy and load-use bubbles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES,
    parameter int MEM_TIMEOUT   = DEF_MEM_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_is_muldiv,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_en,
    output logic       muldiv_busy,
    output logic       mem_err
);

    // A single-cycle mul/div needs no extra EX occupancy.
    localparam bit               MD_EN     = (MULDIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] MD_LOAD   = CNT_W'(MULDIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] WD_SAT    = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrl_state_e      state_reg, state_next;
    logic [CNT_W-1:0] mdcnt_reg, mdcnt_next;
    logic [CNT_W-1:0] wdcnt_reg, wdcnt_next;
    logic             err_reg, err_next;
    logic             luh;
    logic             freeze;

    load_use_detect u_luh (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .luh         (luh)
    );

    assign freeze = mem_req && !mem_ready;

    // State, mul/div countdown, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            mdcnt_reg <= '0;
            wdcnt_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mdcnt_reg <= mdcnt_next;
            wdcnt_reg <= wdcnt_next;
            err_reg   <= err_next;
        end
    end

    // Next-state and stage enable/flush decode, highest-priority condition first.
    always_comb begin
        state_next  = state_reg;
        mdcnt_next  = mdcnt_reg;
        wdcnt_next  = '0;
        err_next    = err_reg;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        muldiv_busy = (state_reg == MULDIV);
        mem_err     = err_reg;

        if (freeze) begin
            // Whole pipeline holds; the sequencer holds too, only the watchdog runs.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            wdcnt_next = (wdcnt_reg == WD_SAT) ? wdcnt_reg : wdcnt_reg + CNT_ONE;
            if (wdcnt_reg >= WD_LAST) begin
                err_next = 1'b1;
            end
        end else if (state_reg == MULDIV) begin
            // EX holds the mul/div: upstream stalls, MEM receives bubbles.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            if (mdcnt_reg == '0) begin
                state_next = RUN;
            end else begin
                mdcnt_next = mdcnt_reg - CNT_ONE;
            end
        end else if (branch_taken) begin
            // Squash the two wrong-path instructions behind the branch.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (luh) begin
            // Hold PC and IF/ID for one cycle and insert one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_is_muldiv && MD_EN) begin
            // Mul/div advances into EX normally, then occupies it.
            state_next = MULDIV;
            mdcnt_next = MD_LOAD;
        end

        // Everything is quiet while held in reset.
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            muldiv_busy = 1'b0;
        end
    end

endmodule
